// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcode bit positions, divider states and the decode-bus layout
// used by the execute stage and its helpers.
package exe_stage_pkg;
   localparam int DS_TO_ES_BUS_WD = 145;
   localparam int ES_TO_MS_BUS_WD = 71;
   localparam int BACK_BUS_WD     = 40;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Field order matches the decode bus, MSB first.
   typedef struct packed {
      logic [11:0] alu_op;
      logic        load_op;
      logic        src1_is_sa;
      logic        src1_is_pc;
      logic        src2_imm_sext;
      logic        src2_imm_zext;
      logic        src2_is_8;
      logic        gr_we;
      logic        mem_we;
      logic        mult;
      logic        multu;
      logic        div;
      logic        divu;
      logic        mfhi;
      logic        mflo;
      logic        mthi;
      logic        mtlo;
      logic [4:0]  dest;
      logic [15:0] imm;
      logic [31:0] rs_value;
      logic [31:0] rt_value;
      logic [31:0] pc;
   } ds_bus_t;
endpackage

// File: rtl/alu.sv
// Single-cycle ALU driven by a one-hot opcode.
module alu
   import exe_stage_pkg::*;
(
   input  logic [11:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] sra_res;

   assign sum     = alu_src1 + alu_src2;
   assign diff    = alu_src1 - alu_src2;
   // Kept separate so the arithmetic shift is not widened into an unsigned context.
   assign sra_res = $signed(alu_src2) >>> alu_src1[4:0];

   always_comb begin
      alu_result = 32'd0;
      if (alu_op[ALU_ADD])  alu_result |= sum;
      if (alu_op[ALU_SUB])  alu_result |= diff;
      if (alu_op[ALU_SLT])  alu_result |= {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      if (alu_op[ALU_SLTU]) alu_result |= {31'd0, alu_src1 < alu_src2};
      if (alu_op[ALU_AND])  alu_result |= alu_src1 & alu_src2;
      if (alu_op[ALU_NOR])  alu_result |= ~(alu_src1 | alu_src2);
      if (alu_op[ALU_OR])   alu_result |= alu_src1 | alu_src2;
      if (alu_op[ALU_XOR])  alu_result |= alu_src1 ^ alu_src2;
      if (alu_op[ALU_SLL])  alu_result |= alu_src2 << alu_src1[4:0];
      if (alu_op[ALU_SRL])  alu_result |= alu_src2 >> alu_src1[4:0];
      if (alu_op[ALU_SRA])  alu_result |= sra_res;
      if (alu_op[ALU_LUI])  alu_result |= {alu_src2[15:0], 16'd0};
   end
endmodule

// File: rtl/exe_stage_div_iter.sv
// Iterative 32-step restoring divider; the result is held in DONE until acknowledged.
module div_iter
   import exe_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sign,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        ack,
   output logic        done,
   output logic [31:0] q,
   output logic [31:0] r
);
   div_state_e  state, state_nxt;
   logic [4:0]  cnt;
   logic [63:0] rem;
   logic [31:0] ya;
   logic [31:0] x_keep;
   logic        neg_q, neg_r, by_zero;
   logic [31:0] xa_in, ya_in;
   logic [32:0] trial;

   assign xa_in = (sign && x[31]) ? -x : x;
   assign ya_in = (sign && y[31]) ? -y : y;
   // Shifted upper half minus divisor; bit 32 set means the subtraction would borrow.
   assign trial = rem[63:31] - {1'b0, ya};

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_IDLE: if (start) state_nxt = DIV_BUSY;
         DIV_BUSY: if (cnt == 5'd0) state_nxt = DIV_DONE;
         DIV_DONE: if (ack) state_nxt = DIV_IDLE;
         default:  state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= DIV_IDLE;
         cnt     <= 5'd0;
         rem     <= 64'd0;
         ya      <= 32'd0;
         x_keep  <= 32'd0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         by_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DIV_IDLE && start) begin
            rem     <= {32'd0, xa_in};
            ya      <= ya_in;
            cnt     <= 5'd31;
            x_keep  <= x;
            neg_q   <= sign && (x[31] ^ y[31]);
            neg_r   <= sign && x[31];
            by_zero <= (y == 32'd0);
         end else if (state == DIV_BUSY) begin
            cnt <= cnt - 5'd1;
            rem <= trial[32] ? {rem[62:0], 1'b0} : {trial[31:0], rem[30:0], 1'b1};
         end
      end
   end

   assign done = (state == DIV_DONE);
   assign q    = by_zero ? 32'hFFFF_FFFF : (neg_q ? -rem[31:0] : rem[31:0]);
   assign r    = by_zero ? x_keep : (neg_r ? -rem[63:32] : rem[63:32]);
endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, runs the ALU, owns HI/LO, drives the data SRAM
// and reports hazard info back to decode.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic [BACK_BUS_WD-1:0]     back_to_id_stage_bus_from_exe,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_wen,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
);
   ds_bus_t            es;
   logic               es_valid;
   logic               es_ready_go;
   logic               fire;
   logic               is_div;
   logic               div_done;
   logic [31:0]        src1, src2, alu_result, es_result;
   logic [31:0]        hi, lo, div_q, div_r;
   logic signed [63:0] sprod;
   logic [63:0]        uprod;

   assign is_div         = es.div | es.divu;
   assign es_ready_go    = is_div ? div_done : 1'b1;
   assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid && es_ready_go;
   assign fire           = es_to_ms_valid && ms_allowin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_to_es_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             es <= '0;
      else if (ds_to_es_valid && es_allowin) es <= ds_bus_t'(ds_to_es_bus);
   end

   assign src1 = es.src1_is_sa    ? {27'd0, es.imm[10:6]} :
                 es.src1_is_pc    ? es.pc : es.rs_value;
   assign src2 = es.src2_imm_sext ? {{16{es.imm[15]}}, es.imm} :
                 es.src2_imm_zext ? {16'd0, es.imm} :
                 es.src2_is_8     ? 32'd8 : es.rt_value;

   alu u_alu (
      .alu_op     (es.alu_op),
      .alu_src1   (src1),
      .alu_src2   (src2),
      .alu_result (alu_result)
   );

   div_iter u_div (
      .clk   (clk),
      .reset (reset),
      .start (es_valid && is_div),
      .sign  (es.div),
      .x     (es.rs_value),
      .y     (es.rt_value),
      .ack   (fire),
      .done  (div_done),
      .q     (div_q),
      .r     (div_r)
   );

   assign sprod = $signed(es.rs_value) * $signed(es.rt_value);
   assign uprod = {32'd0, es.rs_value} * {32'd0, es.rt_value};

   // Written only on fire so a stalled writer commits once and a reader right behind sees it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (fire) begin
         if (es.mult)       {hi, lo} <= sprod;
         else if (es.multu) {hi, lo} <= uprod;
         else if (is_div) begin
            lo <= div_q;
            hi <= div_r;
         end else begin
            if (es.mthi) hi <= es.rs_value;
            if (es.mtlo) lo <= es.rs_value;
         end
      end
   end

   assign es_result = es.mfhi ? hi : es.mflo ? lo : alu_result;

   assign data_sram_en    = es_valid && ms_allowin && (es.load_op || es.mem_we);
   assign data_sram_wen   = (es_valid && es.mem_we && ms_allowin) ? 4'hF : 4'h0;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = es.rt_value;

   assign es_to_ms_bus = {es.load_op, es.gr_we, es.dest, es_result, es.pc};
   assign back_to_id_stage_bus_from_exe = {es.load_op, es_result, es_valid, es.gr_we, es.dest};
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the stage.
module tb_exe_stage;
   import exe_stage_pkg::*;

   logic         clk, reset, ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid;
   logic [144:0] ds_to_es_bus;
   logic [70:0]  es_to_ms_bus;
   logic [39:0]  back;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr, data_sram_wdata;

   int total = 0;
   int bad   = 0;

   exe_stage dut (
      .clk                           (clk),
      .reset                         (reset),
      .ms_allowin                    (ms_allowin),
      .es_allowin                    (es_allowin),
      .ds_to_es_valid                (ds_to_es_valid),
      .ds_to_es_bus                  (ds_to_es_bus),
      .es_to_ms_valid                (es_to_ms_valid),
      .es_to_ms_bus                  (es_to_ms_bus),
      .back_to_id_stage_bus_from_exe (back),
      .data_sram_en                  (data_sram_en),
      .data_sram_wen                 (data_sram_wen),
      .data_sram_addr                (data_sram_addr),
      .data_sram_wdata               (data_sram_wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model helpers ----------------
   function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
      int sb = b;
      if (op[0])  return a + b;
      if (op[1])  return a - b;
      if (op[2])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op[3])  return (a < b) ? 32'd1 : 32'd0;
      if (op[4])  return a & b;
      if (op[5])  return ~(a | b);
      if (op[6])  return a | b;
      if (op[7])  return a ^ b;
      if (op[8])  return b << a[4:0];
      if (op[9])  return b >> a[4:0];
      if (op[10]) return sb >>> a[4:0];
      return {b[15:0], 16'd0};
   endfunction

   function automatic logic [31:0] op1(input ds_bus_t b);
      return b.src1_is_sa ? {27'd0, b.imm[10:6]} : b.src1_is_pc ? b.pc : b.rs_value;
   endfunction

   function automatic logic [31:0] op2(input ds_bus_t b);
      return b.src2_imm_sext ? {{16{b.imm[15]}}, b.imm} :
             b.src2_imm_zext ? {16'd0, b.imm} : b.src2_is_8 ? 32'd8 : b.rt_value;
   endfunction

   // Returns {remainder, quotient}.
   function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      longint a, b;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (sgn) begin
         a = longint'($signed(x));
         b = longint'($signed(y));
      end else begin
         a = longint'({32'd0, x});
         b = longint'({32'd0, y});
      end
      return {32'(a % b), 32'(a / b)};
   endfunction

   // kinds: 0 addu 1 lw 2 sw 3 mult 4 multu 5 div 6 divu 7 mthi 8 mtlo 9 mfhi 10 mflo
   function automatic ds_bus_t mk(input int k, input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
      ds_bus_t b = '0;
      b.alu_op   = 12'd1;
      b.rs_value = rs;
      b.rt_value = rt;
      b.imm      = imm;
      b.dest     = 5'd9;
      b.pc       = 32'hBFC0_0100;
      case (k)
         0:       b.gr_we = 1'b1;
         1:       begin b.load_op = 1'b1; b.gr_we = 1'b1; b.src2_imm_sext = 1'b1; end
         2:       begin b.mem_we = 1'b1; b.src2_imm_sext = 1'b1; end
         3:       b.mult = 1'b1;
         4:       b.multu = 1'b1;
         5:       b.div = 1'b1;
         6:       b.divu = 1'b1;
         7:       b.mthi = 1'b1;
         8:       b.mtlo = 1'b1;
         9:       begin b.mfhi = 1'b1; b.gr_we = 1'b1; end
         default: begin b.mflo = 1'b1; b.gr_we = 1'b1; end
      endcase
      return b;
   endfunction

   function automatic ds_bus_t rand_ins();
      ds_bus_t     b;
      int          p = $urandom_range(0, 99);
      int          k, s1, s2;
      logic [31:0] rs = $urandom;
      logic [31:0] rt = $urandom;
      k = p < 40 ? 0 : p < 50 ? 1 : p < 58 ? 2 : p < 64 ? 3 : p < 68 ? 4 : p < 71 ? 5 :
          p < 74 ? 6 : p < 79 ? 7 : p < 84 ? 8 : p < 92 ? 9 : 10;
      if ((k == 5 || k == 6) && $urandom_range(0, 3) == 0) rt = 32'd0;
      if (k == 5 && $urandom_range(0, 7) == 0) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
      b      = mk(k, rs, rt, 16'($urandom));
      b.dest = 5'($urandom);
      b.pc   = $urandom;
      if (k == 0) begin
         b.alu_op        = 12'd1 << $urandom_range(0, 11);
         s1              = $urandom_range(0, 2);
         s2              = $urandom_range(0, 3);
         b.src1_is_sa    = (s1 == 1);
         b.src1_is_pc    = (s1 == 2);
         b.src2_imm_sext = (s2 == 1);
         b.src2_imm_zext = (s2 == 2);
         b.src2_is_8     = (s2 == 3);
      end
      return b;
   endfunction

   // ---------------- model state and per-cycle compare ----------------
   logic        m_valid = 1'b0;
   ds_bus_t     m_ins   = '0;
   int          m_age   = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic        m_ready;
   logic [31:0] m_alu, m_res;
   longint      ma, mb;

   always @(negedge clk) begin
      if (reset) begin
         m_valid = 1'b0;
         m_hi    = 32'd0;
         m_lo    = 32'd0;
         m_age   = 0;
         check("rst_to_ms_valid", es_to_ms_valid, 1'b0);
         check("rst_sram_en", data_sram_en, 1'b0);
         check("rst_sram_wen", data_sram_wen, 4'h0);
         check("rst_back_valid", back[6], 1'b0);
      end else begin
         // A divide becomes ready 33 cycles after it first occupies the stage.
         m_ready = !(m_ins.div || m_ins.divu) || (m_age >= 33);
         check("es_allowin", es_allowin, !m_valid || (m_ready && ms_allowin));
         check("es_to_ms_valid", es_to_ms_valid, m_valid && m_ready);
         check("sram_en", data_sram_en, m_valid && ms_allowin && (m_ins.load_op || m_ins.mem_we));
         check("sram_wen", data_sram_wen, (m_valid && ms_allowin && m_ins.mem_we) ? 4'hF : 4'h0);
         check("back_valid", back[6], m_valid);
         if (m_valid) begin
            m_alu = alu_ref(m_ins.alu_op, op1(m_ins), op2(m_ins));
            m_res = m_ins.mfhi ? m_hi : m_ins.mflo ? m_lo : m_alu;
            check("to_ms_bus", es_to_ms_bus, {m_ins.load_op, m_ins.gr_we, m_ins.dest, m_res, m_ins.pc});
            check("back_bus", back, {m_ins.load_op, m_res, 1'b1, m_ins.gr_we, m_ins.dest});
            check("sram_addr", data_sram_addr, m_alu);
            check("sram_wdata", data_sram_wdata, m_ins.rt_value);
         end
         if (m_valid && m_ready && ms_allowin) begin
            if (m_ins.mult) begin
               ma = longint'($signed(m_ins.rs_value));
               mb = longint'($signed(m_ins.rt_value));
               {m_hi, m_lo} = ma * mb;
            end else if (m_ins.multu) begin
               ma = longint'({32'd0, m_ins.rs_value});
               mb = longint'({32'd0, m_ins.rt_value});
               {m_hi, m_lo} = ma * mb;
            end else if (m_ins.div || m_ins.divu) begin
               {m_hi, m_lo} = div_ref(m_ins.div, m_ins.rs_value, m_ins.rt_value);
            end else begin
               if (m_ins.mthi) m_hi = m_ins.rs_value;
               if (m_ins.mtlo) m_lo = m_ins.rs_value;
            end
         end
         if (!m_valid || (m_ready && ms_allowin)) begin
            m_valid = ds_to_es_valid;
            if (ds_to_es_valid) begin
               m_ins = ds_to_es_bus;
               m_age = 0;
            end
         end else begin
            m_age++;
         end
      end
   end

   // ---------------- directed stimulus helpers ----------------
   task automatic send(input ds_bus_t b);
      int   n = 0;
      logic acc;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = b;
      do begin
         @(negedge clk);
         acc = es_allowin;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout actual=stalled expected=accepted");
      end
      ds_to_es_valid = 1'b0;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!es_allowin && cnt < 100) begin
         cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   int stall;

   initial begin
      reset          = 1'b1;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_allowin", es_allowin, 1'b1);
      check("reset_to_ms_valid", es_to_ms_valid, 1'b0);
      #2 reset = 1'b0;

      // addu 5 + 7
      send(mk(0, 32'd5, 32'd7, 16'd0));
      check("addu_result", es_to_ms_bus[63:32], 32'd12);
      check("addu_valid", es_to_ms_valid, 1'b1);
      check("addu_back_dest", back[4:0], 5'd9);
      check("addu_back_we", back[5], 1'b1);
      @(posedge clk);
      #1;

      // sw held off by the memory stage for three cycles
      ms_allowin = 1'b0;
      send(mk(2, 32'h1000, 32'hDEAD, 16'd4));
      repeat (3) begin
         check("sw_stall_en", data_sram_en, 1'b0);
         check("sw_stall_wen", data_sram_wen, 4'h0);
         @(posedge clk);
         #1;
      end
      ms_allowin = 1'b1;
      #1;
      check("sw_wen", data_sram_wen, 4'hF);
      check("sw_addr", data_sram_addr, 32'h1004);
      check("sw_wdata", data_sram_wdata, 32'hDEAD);
      @(posedge clk);
      #1;
      check("sw_once", data_sram_wen, 4'h0);

      // mult -3 * 4, read back-to-back
      send(mk(3, 32'hFFFF_FFFD, 32'd4, 16'd0));
      send(mk(9, 32'd0, 32'd0, 16'd0));
      check("mult_hi", es_to_ms_bus[63:32], 32'hFFFF_FFFF);
      send(mk(10, 32'd0, 32'd0, 16'd0));
      check("mult_lo", es_to_ms_bus[63:32], 32'hFFFF_FFF4);

      // div -7 / 2
      send(mk(5, 32'hFFFF_FFF9, 32'd2, 16'd0));
      wait_ready(stall);
      check("div_stall_cycles", stall, 33);
      send(mk(10, 32'd0, 32'd0, 16'd0));
      check("div_lo", es_to_ms_bus[63:32], 32'hFFFF_FFFD);
      send(mk(9, 32'd0, 32'd0, 16'd0));
      check("div_hi", es_to_ms_bus[63:32], 32'hFFFF_FFFF);

      // divu 7 / 0
      send(mk(6, 32'd7, 32'd0, 16'd0));
      wait_ready(stall);
      check("divu0_stall_cycles", stall, 33);
      send(mk(10, 32'd0, 32'd0, 16'd0));
      check("divu0_lo", es_to_ms_bus[63:32], 32'hFFFF_FFFF);
      send(mk(9, 32'd0, 32'd0, 16'd0));
      check("divu0_hi", es_to_ms_bus[63:32], 32'd7);

      // lw hazard info and request
      send(mk(1, 32'h2000, 32'd0, 16'd8));
      check("lw_back_load", back[39], 1'b1);
      check("lw_en", data_sram_en, 1'b1);
      check("lw_wen", data_sram_wen, 4'h0);
      check("lw_addr", data_sram_addr, 32'h2008);
      @(posedge clk);
      #1;
      check("idle_back_valid", back[6], 1'b0);

      // reset in the middle of a divide
      send(mk(7, 32'h55, 32'd0, 16'd0));
      send(mk(5, 32'd100, 32'd7, 16'd0));
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_back_valid", back[6], 1'b0);
      check("midrst_allowin", es_allowin, 1'b1);
      @(posedge clk);
      #3 reset = 1'b0;
      send(mk(9, 32'd0, 32'd0, 16'd0));
      check("midrst_hi_clear", es_to_ms_bus[63:32], 32'd0);
      send(mk(10, 32'd0, 32'd0, 16'd0));
      check("midrst_lo_clear", es_to_ms_bus[63:32], 32'd0);
      send(mk(5, 32'd100, 32'd7, 16'd0));
      wait_ready(stall);
      check("postrst_div_stall", stall, 33);
      send(mk(10, 32'd0, 32'd0, 16'd0));
      check("postrst_div_lo", es_to_ms_bus[63:32], 32'd14);
      send(mk(9, 32'd0, 32'd0, 16'd0));
      check("postrst_div_hi", es_to_ms_bus[63:32], 32'd2);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         ds_to_es_valid = ($urandom_range(0, 3) != 0);
         ds_to_es_bus   = rand_ins();
         ms_allowin     = ($urandom_range(0, 4) != 0);
      end
      @(posedge clk);
      #1;
      ds_to_es_valid = 1'b0;
      ms_allowin     = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
